pmem_write_arbiter: RTL and testbench
=====================================

PMEM_WRITE_ARBITER -- requirements
Module: pmem_write_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; clock and reset ports are named as below.
REQ-002 Parameter GAP_CYCLES, default 0: idle cycles inserted after each issued write (0..15).
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 reqN_valid_i  in  1  requester N (N=0,1) has a write pending.
REQ-006 reqN_ready_o  out  1  requester N write accepted this cycle when valid also high.
REQ-007 reqN_addr_i / reqN_strb_i / reqN_data_i  in  32/4/32  requester N byte address, byte strobe, write data.
REQ-008 reqN_done_o  out  1  one-cycle pulse: requester N's accepted write has been issued.
REQ-009 pmem_en_o  out  1  write strobe to the pmem write DPI port.
REQ-010 pmem_addr_o / pmem_strb_o / pmem_data_o  out  32/4/32  registered write payload.
REQ-011 busy_o  out  1  high when FSM is not IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, ISSUE, GAP.
- IDLE -> ISSUE on any handshake (valid & ready).
- ISSUE -> GAP if GAP_CYCLES>0, else ISSUE -> IDLE; ISSUE lasts exactly 1 cycle.
- GAP -> IDLE after exactly GAP_CYCLES cycles, counted by a 4-bit down-counter loaded on ISSUE entry.
REQ-013 reqN_ready_o SHALL be combinational, high only in IDLE and only for the arbitration winner; at most one ready high per cycle.
REQ-014 Arbitration SHALL be round-robin: one valid -> that requester wins; both valid -> the requester not granted last wins.
REQ-015 A last_grant register SHALL update only on a handshake; reset value 1, so port 0 wins the first contention.
REQ-016 On handshake in cycle T, the winner's addr/strb/data SHALL be captured into the output registers at the end of T.
REQ-017 In cycle T+1 (ISSUE), pmem_en_o SHALL be high iff the captured strb != 4'b0000.
REQ-018 reqN_done_o SHALL pulse in T+1 for the winner regardless of strb; a zero-strobe write is acknowledged but never reaches pmem.
REQ-019 pmem_addr_o/strb_o/data_o SHALL hold the last captured value outside ISSUE; consumers sample only when pmem_en_o=1.
REQ-020 Throughput SHALL be one write per (2+GAP_CYCLES) cycles when requests are back-to-back.
REQ-021 Requesters SHALL hold valid and payload stable until ready; a valid deasserted before ready SHALL be dropped without side effect.
REQ-022 Requests arriving in ISSUE or GAP SHALL see ready=0 and wait; no request SHALL be lost or issued twice.
REQ-023 Address, data and strobe SHALL pass unmodified; no alignment check or byte shifting is performed.

Reset
REQ-024 While reset=0: FSM=IDLE, gap counter=0, last_grant=1, pmem_en_o=0, pmem_addr_o/strb_o/data_o=0, reqN_done_o=0, busy_o=0.
REQ-025 Reset asserted mid-ISSUE SHALL drop pmem_en_o and done immediately (asynchronous), and the in-flight write SHALL be discarded.
REQ-026 On reset release with valid already high, the first handshake SHALL occur in the first clock edge after release; no DPI write SHALL be generated during reset.

Verification
REQ-027 GAP_CYCLES=0; req0 valid, addr=0x80000000, strb=0xF, data=0xDEADBEEF -> ready0 in T; pmem_en_o=1 with the same payload and done0=1 in T+1; busy_o=0 in T+2.
REQ-028 Both valid continuously after reset -> grant order 0,1,0,1; pmem_en_o pulses every 2nd cycle; never two readies in one cycle.
REQ-029 req1 with strb=0x0, data=0x12345678 -> done1 pulses in T+1; pmem_en_o stays 0.
REQ-030 GAP_CYCLES=3; req0 held valid for 3 writes -> pmem_en_o pulses exactly 5 cycles apart; busy_o high for 4 cycles after each handshake.
REQ-031 Assert reset during ISSUE -> pmem_en_o=0 within the same cycle; after release, outputs equal the reset values; re-presented request issues once.
REQ-032 req0 valid arrives during GAP while req1 was last granted -> req0 accepted on first IDLE cycle; no lost or duplicate write (scoreboard compares request and pmem logs).

Source files
------------

// File: rtl/pmem_write_arbiter_if.sv
// pmem_write_arbiter_if
// Bundles the two requester write channels and the pmem write port of the
// two-requester pmem write arbiter.
//   req0_* / req1_*   : requester channels (valid/ready handshake, byte address,
//                       byte strobe, write data, one-cycle done pulse)
//   pmem_*            : registered write payload and write strobe towards pmem
//   busy_o            : arbiter is in the middle of a write (not idle)
// The slave modport is the arbiter's view; the master modport is the view of
// whatever drives the requests and consumes the pmem port.
interface pmem_write_arbiter_if;
  logic        req0_valid_i;
  logic        req0_ready_o;
  logic [31:0] req0_addr_i;
  logic [3:0]  req0_strb_i;
  logic [31:0] req0_data_i;
  logic        req0_done_o;

  logic        req1_valid_i;
  logic        req1_ready_o;
  logic [31:0] req1_addr_i;
  logic [3:0]  req1_strb_i;
  logic [31:0] req1_data_i;
  logic        req1_done_o;

  logic        pmem_en_o;
  logic [31:0] pmem_addr_o;
  logic [3:0]  pmem_strb_o;
  logic [31:0] pmem_data_o;
  logic        busy_o;

  modport slave (
    input  req0_valid_i, req0_addr_i, req0_strb_i, req0_data_i,
    input  req1_valid_i, req1_addr_i, req1_strb_i, req1_data_i,
    output req0_ready_o, req0_done_o,
    output req1_ready_o, req1_done_o,
    output pmem_en_o, pmem_addr_o, pmem_strb_o, pmem_data_o, busy_o
  );

  modport master (
    output req0_valid_i, req0_addr_i, req0_strb_i, req0_data_i,
    output req1_valid_i, req1_addr_i, req1_strb_i, req1_data_i,
    input  req0_ready_o, req0_done_o,
    input  req1_ready_o, req1_done_o,
    input  pmem_en_o, pmem_addr_o, pmem_strb_o, pmem_data_o, busy_o
  );
endinterface

// File: rtl/pmem_write_arbiter.sv
// pmem_write_arbiter
// Round-robin arbiter that funnels writes from two requesters into a single
// pmem write port. One write is accepted in IDLE, issued for exactly one cycle
// in ISSUE, then optionally followed by GAP_CYCLES idle cycles in GAP.
// Ports:
//   clock  : sole clock, rising edge
//   reset  : asynchronous, active-low reset
//   bus    : pmem_write_arbiter_if.slave (requester channels + pmem port)
// Parameter:
//   GAP_CYCLES : idle cycles inserted after each issued write (0..15)
module pmem_write_arbiter #(
  parameter int unsigned GAP_CYCLES = 0
) (
  input logic                  clock,
  input logic                  reset,
  pmem_write_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);

  state_t      state;
  logic [3:0]  gap_cnt;
  logic        last_grant;
  logic        pmem_en;
  logic        done0;
  logic        done1;
  logic        busy;
  logic [31:0] addr_q;
  logic [3:0]  strb_q;
  logic [31:0] data_q;

  logic        winner;
  logic        ready0;
  logic        ready1;
  logic        handshake;
  logic [31:0] sel_addr;
  logic [3:0]  sel_strb;
  logic [31:0] sel_data;

  // Round-robin pick: a lone valid requester wins outright; under contention
  // the requester that was not granted last time wins. last_grant resets to 1
  // so requester 0 takes the very first contention.
  always_comb begin
    winner = 1'b0;
    if (bus.req0_valid_i && bus.req1_valid_i) begin
      winner = ~last_grant;
    end else if (bus.req1_valid_i) begin
      winner = 1'b1;
    end
  end

  // Ready is combinational so a waiting requester is accepted in the first
  // IDLE cycle; only the winner ever sees ready, so at most one is high.
  assign ready0    = (state == IDLE) && bus.req0_valid_i && !winner;
  assign ready1    = (state == IDLE) && bus.req1_valid_i && winner;
  assign handshake = ready0 || ready1;

  // Winner's payload, captured on the handshake edge.
  always_comb begin
    sel_addr = bus.req0_addr_i;
    sel_strb = bus.req0_strb_i;
    sel_data = bus.req0_data_i;
    if (winner) begin
      sel_addr = bus.req1_addr_i;
      sel_strb = bus.req1_strb_i;
      sel_data = bus.req1_data_i;
    end
  end

  // Main FSM with registered outputs. pmem_en and done are single-cycle
  // pulses that are only ever set on the IDLE->ISSUE transition, so they are
  // high exactly during ISSUE. A zero strobe still produces done but keeps
  // pmem_en low. The gap counter is loaded on ISSUE entry and counts down in
  // GAP; the payload registers hold their value until the next handshake.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      gap_cnt    <= 4'd0;
      last_grant <= 1'b1;
      pmem_en    <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      busy       <= 1'b0;
      addr_q     <= 32'd0;
      strb_q     <= 4'd0;
      data_q     <= 32'd0;
    end else begin
      pmem_en <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (handshake) begin
            state      <= ISSUE;
            busy       <= 1'b1;
            last_grant <= winner;
            addr_q     <= sel_addr;
            strb_q     <= sel_strb;
            data_q     <= sel_data;
            pmem_en    <= (sel_strb != 4'd0);
            done0      <= !winner;
            done1      <= winner;
            gap_cnt    <= GAP_LOAD;
          end
        end
        ISSUE: begin
          if (GAP_LOAD != 4'd0) begin
            state <= GAP;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        GAP: begin
          if (gap_cnt <= 4'd1) begin
            state   <= IDLE;
            busy    <= 1'b0;
            gap_cnt <= 4'd0;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req0_ready_o = ready0;
  assign bus.req1_ready_o = ready1;
  assign bus.req0_done_o  = done0;
  assign bus.req1_done_o  = done1;
  assign bus.pmem_en_o    = pmem_en;
  assign bus.pmem_addr_o  = addr_q;
  assign bus.pmem_strb_o  = strb_q;
  assign bus.pmem_data_o  = data_q;
  assign bus.busy_o       = busy;

endmodule

// File: tb/tb_pmem_write_arbiter.sv
// tb_pmem_write_arbiter
// Self-checking bench for pmem_write_arbiter. Two instances are exercised:
// "a" with GAP_CYCLES=0 and "b" with GAP_CYCLES=3. A small cycle model per
// instance predicts ready/busy/pmem_en/done each cycle, and a scoreboard
// queue per instance holds accepted requests until the matching done pulse,
// where the issued payload is compared against the request.
module tb_pmem_write_arbiter;

  typedef struct packed {
    logic        port;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } sb_item_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  int checkCount = 0;
  int errorCount = 0;

  sb_item_t sbQueueA[$];
  sb_item_t sbQueueB[$];

  int       mState[2];
  int       mCnt[2];
  logic     mLast[2];
  logic     mPort[2];
  logic [3:0] mStrb[2];

  pmem_write_arbiter_if bus_a();
  pmem_write_arbiter_if bus_b();

  pmem_write_arbiter #(.GAP_CYCLES(0)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  pmem_write_arbiter #(.GAP_CYCLES(3)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic sbPush(input int k, input sb_item_t item);
    if (k == 0) sbQueueA.push_back(item);
    else        sbQueueB.push_back(item);
  endtask

  function automatic int sbSize(input int k);
    return (k == 0) ? sbQueueA.size() : sbQueueB.size();
  endfunction

  task automatic sbPop(input int k, output sb_item_t item);
    if (k == 0) item = sbQueueA.pop_front();
    else        item = sbQueueB.pop_front();
  endtask

  task automatic sbClear(input int k);
    if (k == 0) sbQueueA.delete();
    else        sbQueueB.delete();
  endtask

  // One cycle of the reference model, called at the falling edge. p0/p1 are
  // the driven requests; the remaining inputs are the observed DUT outputs.
  task automatic modelCycle(input int k, input int gap, input string pfx, input logic rstN,
                            input logic v0, input logic v1, input sb_item_t p0, input sb_item_t p1,
                            input logic r0, input logic r1, input logic en, input logic d0,
                            input logic d1, input logic bsy, input logic [31:0] paddr,
                            input logic [3:0] pstrb, input logic [31:0] pdata);
    logic er0, er1;
    sb_item_t item;
    if (!rstN) begin
      checkOutput({pfx, "_rst_en"},   en,    0);
      checkOutput({pfx, "_rst_done0"}, d0,   0);
      checkOutput({pfx, "_rst_done1"}, d1,   0);
      checkOutput({pfx, "_rst_busy"}, bsy,   0);
      checkOutput({pfx, "_rst_addr"}, paddr, 0);
      checkOutput({pfx, "_rst_strb"}, pstrb, 0);
      checkOutput({pfx, "_rst_data"}, pdata, 0);
      mState[k] = 0;
      mCnt[k]   = 0;
      mLast[k]  = 1'b1;
      sbClear(k);
      return;
    end
    er0 = (mState[k] == 0) && v0 && (!v1 || mLast[k] == 1'b1);
    er1 = (mState[k] == 0) && v1 && (!v0 || mLast[k] == 1'b0);
    checkOutput({pfx, "_ready0"}, r0, er0);
    checkOutput({pfx, "_ready1"}, r1, er1);
    checkOutput({pfx, "_busy"}, bsy, mState[k] != 0);
    checkOutput({pfx, "_pmem_en"}, en, (mState[k] == 1) && (mStrb[k] != 4'd0));
    checkOutput({pfx, "_done0"}, d0, (mState[k] == 1) && (mPort[k] == 1'b0));
    checkOutput({pfx, "_done1"}, d1, (mState[k] == 1) && (mPort[k] == 1'b1));
    if (d0 || d1) begin
      if (sbSize(k) == 0) begin
        checkOutput({pfx, "_sb_underflow"}, 1, 0);
      end else begin
        sbPop(k, item);
        checkOutput({pfx, "_sb_port"}, d1, item.port);
        checkOutput({pfx, "_sb_en"}, en, item.strb != 4'd0);
        checkOutput({pfx, "_sb_addr"}, paddr, item.addr);
        checkOutput({pfx, "_sb_strb"}, pstrb, item.strb);
        checkOutput({pfx, "_sb_data"}, pdata, item.data);
      end
    end
    if (v0 && r0) sbPush(k, p0);
    if (v1 && r1) sbPush(k, p1);
    case (mState[k])
      0: if (er0 || er1) begin
           mState[k] = 1;
           mPort[k]  = er0 ? 1'b0 : 1'b1;
           mStrb[k]  = er0 ? p0.strb : p1.strb;
           mLast[k]  = mPort[k];
         end
      1: begin
           mCnt[k]   = gap;
           mState[k] = (gap > 0) ? 2 : 0;
         end
      default: begin
           mCnt[k] = mCnt[k] - 1;
           if (mCnt[k] == 0) mState[k] = 0;
         end
    endcase
  endtask

  always @(negedge clock) begin
    modelCycle(0, 0, "a", reset, bus_a.req0_valid_i, bus_a.req1_valid_i,
               {1'b0, bus_a.req0_addr_i, bus_a.req0_strb_i, bus_a.req0_data_i},
               {1'b1, bus_a.req1_addr_i, bus_a.req1_strb_i, bus_a.req1_data_i},
               bus_a.req0_ready_o, bus_a.req1_ready_o, bus_a.pmem_en_o,
               bus_a.req0_done_o, bus_a.req1_done_o, bus_a.busy_o,
               bus_a.pmem_addr_o, bus_a.pmem_strb_o, bus_a.pmem_data_o);
    modelCycle(1, 3, "b", reset, bus_b.req0_valid_i, bus_b.req1_valid_i,
               {1'b0, bus_b.req0_addr_i, bus_b.req0_strb_i, bus_b.req0_data_i},
               {1'b1, bus_b.req1_addr_i, bus_b.req1_strb_i, bus_b.req1_data_i},
               bus_b.req0_ready_o, bus_b.req1_ready_o, bus_b.pmem_en_o,
               bus_b.req0_done_o, bus_b.req1_done_o, bus_b.busy_o,
               bus_b.pmem_addr_o, bus_b.pmem_strb_o, bus_b.pmem_data_o);
  end

  task automatic setReq(input int k, input int port, input logic valid,
                        input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data);
    if (k == 0 && port == 0) begin
      bus_a.req0_valid_i = valid; bus_a.req0_addr_i = addr;
      bus_a.req0_strb_i  = strb;  bus_a.req0_data_i = data;
    end else if (k == 0) begin
      bus_a.req1_valid_i = valid; bus_a.req1_addr_i = addr;
      bus_a.req1_strb_i  = strb;  bus_a.req1_data_i = data;
    end else if (port == 0) begin
      bus_b.req0_valid_i = valid; bus_b.req0_addr_i = addr;
      bus_b.req0_strb_i  = strb;  bus_b.req0_data_i = data;
    end else begin
      bus_b.req1_valid_i = valid; bus_b.req1_addr_i = addr;
      bus_b.req1_strb_i  = strb;  bus_b.req1_data_i = data;
    end
  endtask

  function automatic logic getReady(input int k, input int port);
    if (k == 0) return (port == 0) ? bus_a.req0_ready_o : bus_a.req1_ready_o;
    return (port == 0) ? bus_b.req0_ready_o : bus_b.req1_ready_o;
  endfunction

  // Presents one request (called just after a rising edge), holds it until
  // ready is seen, then drops valid one step after the accepting edge.
  task automatic applyStimulus(input int k, input int port, input logic [31:0] addr,
                               input logic [3:0] strb, input logic [31:0] data,
                               output int waited);
    bit accepted = 0;
    waited = 0;
    setReq(k, port, 1'b1, addr, strb, data);
    while (!accepted) begin
      @(negedge clock);
      if (getReady(k, port)) begin
        accepted = 1;
      end else begin
        waited++;
        if (waited >= 100) begin
          checkOutput($sformatf("timeout_k%0d_p%0d", k, port), 1, 0);
          accepted = 1;
        end
      end
    end
    @(posedge clock);
    #1;
    setReq(k, port, 1'b0, addr, strb, data);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    setReq(0, 0, 1'b0, 32'd0, 4'd0, 32'd0);
    setReq(0, 1, 1'b0, 32'd0, 4'd0, 32'd0);
    setReq(1, 0, 1'b0, 32'd0, 4'd0, 32'd0);
    setReq(1, 1, 1'b0, 32'd0, 4'd0, 32'd0);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    $display("[TB] reset released");

    // Single full-strobe write on requester 0.
    applyStimulus(0, 0, 32'h8000_0000, 4'hF, 32'hDEAD_BEEF, w);
    checkOutput("a_first_hs_wait", w, 0);
    idleCycles(3);

    // Zero-strobe write on requester 1: acknowledged, never reaches pmem.
    applyStimulus(0, 1, 32'h0000_1000, 4'h0, 32'h1234_5678, w);
    idleCycles(3);

    // Both requesters valid back to back: alternating grants.
    fork
      begin
        int w0;
        for (int i = 0; i < 3; i++)
          applyStimulus(0, 0, 32'h100 + 32'(i * 4), 4'hF, 32'hA000 + 32'(i), w0);
      end
      begin
        int w1;
        for (int j = 0; j < 3; j++)
          applyStimulus(0, 1, 32'h200 + 32'(j * 4), 4'h3, 32'hB000 + 32'(j), w1);
      end
    join
    idleCycles(3);

    // Random contention traffic on the GAP_CYCLES=0 instance.
    fork
      begin
        int w2;
        for (int i = 0; i < 4; i++)
          applyStimulus(0, 0, $urandom, 4'($urandom_range(0, 15)), $urandom, w2);
      end
      begin
        int w3;
        for (int j = 0; j < 4; j++)
          applyStimulus(0, 1, $urandom, 4'($urandom_range(0, 15)), $urandom, w3);
      end
    join
    idleCycles(3);

    // GAP_CYCLES=3: three back-to-back writes from requester 0.
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 0, 32'h3000 + 32'(i * 4), 4'hF, 32'hC000 + 32'(i), w);
    idleCycles(6);

    // Request raised and dropped during ISSUE/GAP must vanish without effect.
    applyStimulus(1, 1, 32'h4000, 4'h1, 32'h0000_0011, w);
    setReq(1, 1, 1'b1, 32'h4444, 4'hF, 32'h0BAD_0BAD);
    idleCycles(1);
    setReq(1, 1, 1'b0, 32'h4444, 4'hF, 32'h0BAD_0BAD);
    idleCycles(6);

    // Requester 1 granted last; both show up during GAP, requester 0 first.
    applyStimulus(1, 1, 32'h5000, 4'hF, 32'h5555_0001, w);
    idleCycles(1);
    fork
      applyStimulus(1, 0, 32'h6000, 4'hC, 32'h6666_0000, w);
      begin
        int w4;
        applyStimulus(1, 1, 32'h5004, 4'hF, 32'h5555_0002, w4);
      end
    join
    idleCycles(6);

    // Reset asserted during ISSUE, request still presented across release.
    setReq(0, 0, 1'b1, 32'h4000_0010, 4'hF, 32'hCAFE_F00D);
    @(negedge clock);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("a_rst_async_en", bus_a.pmem_en_o, 0);
    checkOutput("a_rst_async_done0", bus_a.req0_done_o, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("a_post_rst_addr", bus_a.pmem_addr_o, 0);
    checkOutput("a_post_rst_data", bus_a.pmem_data_o, 0);
    checkOutput("a_post_rst_en", bus_a.pmem_en_o, 0);
    applyStimulus(0, 0, 32'h4000_0010, 4'hF, 32'hCAFE_F00D, w);
    checkOutput("a_rst_release_hs_wait", w, 0);
    idleCycles(4);

    checkOutput("a_sb_drain", sbQueueA.size(), 0);
    checkOutput("b_sb_drain", sbQueueB.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
